// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// npu_pkg : FSM state type and arithmetic helpers shared by the npu_gemm block.
// Build option: NPU_SAT_EN selects saturating (vs. wrapping) write-back.
// Revision: 1.0
// ============================================================================
package npu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FEED = 2'd1,
      S_WB   = 2'd2,
      S_DONE = 2'd3
   } npu_state_e;

   // Working width for result formatting; covers DATA_W up to 120 bits.
   localparam int FMT_W = 256;

   function automatic int npu_acc_w(input int data_w, input int n);
      return 2 * data_w + $clog2(n) + 1;
   endfunction

   // Caller keeps the low dw bits of the returned value.
   function automatic logic signed [FMT_W-1:0] npu_fmt(input logic signed [FMT_W-1:0] v,
                                                      input int dw);
`ifdef NPU_SAT_EN
      logic signed [FMT_W-1:0] hi;
      logic signed [FMT_W-1:0] lo;
      hi = (FMT_W'(1) <<< (dw - 1)) - FMT_W'(1);
      lo = -hi - FMT_W'(1);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
`else
      return v & ((FMT_W'(1) <<< dw) - FMT_W'(1));
`endif
   endfunction

endpackage
`default_nettype wire

// File: rtl/npu_systolic_array.sv
`default_nettype none
// ============================================================================
// npu_systolic_array : N x N output-stationary MAC grid; A flows right, B down.
// Revision: 1.0
// ============================================================================
module npu_systolic_array
   import npu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int N      = 3,
   parameter int ACC_W  = npu_acc_w(DATA_W, N)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          clr_i,
   input  logic                          en_i,
   input  logic [N-1:0][DATA_W-1:0]      a_row_i,
   input  logic [N-1:0][DATA_W-1:0]      b_col_i,
   output logic [N*N-1:0][ACC_W-1:0]     acc_o
);

   // Inter-PE operand links; only PEs with a downstream neighbour own a pass register.
   logic [DATA_W-1:0] a_link [N][N-1];
   logic [DATA_W-1:0] b_link [N-1][N];

   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
         logic signed [DATA_W-1:0]   a_in;
         logic signed [DATA_W-1:0]   b_in;
         logic signed [2*DATA_W-1:0] prod;
         logic signed [ACC_W-1:0]    acc_q;

         if (c == 0) begin : g_a_edge
            assign a_in = a_row_i[r];
         end else begin : g_a_link
            assign a_in = a_link[r][c-1];
         end

         if (r == 0) begin : g_b_edge
            assign b_in = b_col_i[c];
         end else begin : g_b_link
            assign b_in = b_link[r-1][c];
         end

         assign prod = a_in * b_in;

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               acc_q <= '0;
            end else if (clr_i) begin
               acc_q <= '0;
            end else if (en_i) begin
               acc_q <= acc_q + ACC_W'(prod);
            end
         end

         assign acc_o[r*N + c] = acc_q;

         if (c < N-1) begin : g_a_pass
            logic [DATA_W-1:0] a_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
               if (!rst_ni) begin
                  a_q <= '0;
               end else if (clr_i) begin
                  a_q <= '0;
               end else if (en_i) begin
                  a_q <= a_in;
               end
            end
            assign a_link[r][c] = a_q;
         end

         if (r < N-1) begin : g_b_pass
            logic [DATA_W-1:0] b_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
               if (!rst_ni) begin
                  b_q <= '0;
               end else if (clr_i) begin
                  b_q <= '0;
               end else if (en_i) begin
                  b_q <= b_in;
               end
            end
            assign b_link[r][c] = b_q;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/npu_gemm.sv
`default_nettype none
// ============================================================================
// npu_gemm : N x N systolic GEMM engine with local operand/result memory.
// Build option: NPU_SAT_EN saturates write-back results instead of wrapping.
// Revision: 1.0
// ============================================================================
module npu_gemm
   import npu_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int N      = 3,
   parameter  int DEPTH  = 64,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [AW-1:0]     src1_addr_i,
   input  logic [AW-1:0]     src2_addr_i,
   input  logic [AW-1:0]     dst_addr_i,
   input  logic              acc_mode_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              cmd_err_o,
   input  logic              mem_we_i,
   input  logic              mem_re_i,
   input  logic [AW-1:0]     mem_addr_i,
   input  logic [DATA_W-1:0] mem_wd_i,
   output logic [DATA_W-1:0] mem_rd_o
);

   localparam int ACC_W = npu_acc_w(DATA_W, N);
   localparam int NN    = N * N;
   localparam int TW    = $clog2(3 * N);
   localparam int RW    = $clog2(N);

   npu_state_e        state_q;
   logic [TW-1:0]     t_q;
   logic [RW-1:0]     r_q;
   logic [AW-1:0]     src1_q;
   logic [AW-1:0]     src2_q;
   logic [AW-1:0]     dst_q;
   logic              acc_mode_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic [DATA_W-1:0] rd_q;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic                         cmd_bad;
   logic                         cmd_go;
   logic                         host_in_range;
   logic [N-1:0][DATA_W-1:0]     a_feed;
   logic [N-1:0][DATA_W-1:0]     b_feed;
   logic [NN-1:0][ACC_W-1:0]     acc_flat;
   logic [AW-1:0]                wb_addr [N];
   logic signed [FMT_W-1:0]      wb_sum  [N];
   logic [N-1:0][DATA_W-1:0]     wb_word_d;

   function automatic logic span_bad(input logic [AW-1:0] base);
      return (int'(base) + NN - 1) >= DEPTH;
   endfunction

   assign cmd_bad       = span_bad(src1_addr_i) | span_bad(src2_addr_i) | span_bad(dst_addr_i);
   assign cmd_go        = (state_q == S_IDLE) && start_i && !cmd_bad;
   assign host_in_range = int'(mem_addr_i) < DEPTH;

   // Skewed operand fetch: row i sees A[i][t-i], column j sees B[t-j][j].
   always_comb begin
      a_feed = '0;
      b_feed = '0;
      for (int i = 0; i < N; i++) begin
         if ((state_q == S_FEED) && (int'(t_q) >= i) && (int'(t_q) - i < N)) begin
            a_feed[i] = mem_q[AW'(int'(src1_q) + i * N + int'(t_q) - i)];
            b_feed[i] = mem_q[AW'(int'(src2_q) + (int'(t_q) - i) * N + i)];
         end
      end
   end

   npu_systolic_array #(
      .DATA_W (DATA_W),
      .N      (N),
      .ACC_W  (ACC_W)
   ) u_array (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (cmd_go),
      .en_i    (state_q == S_FEED),
      .a_row_i (a_feed),
      .b_col_i (b_feed),
      .acc_o   (acc_flat)
   );

   // Accumulate mode reads the old destination word in the same cycle it is rewritten.
   always_comb begin
      wb_addr   = '{default: '0};
      wb_sum    = '{default: '0};
      wb_word_d = '0;
      for (int j = 0; j < N; j++) begin
         wb_addr[j] = AW'(int'(dst_q) + int'(r_q) * N + j);
         wb_sum[j]  = FMT_W'(signed'(acc_flat[int'(r_q) * N + j]));
         if (acc_mode_q) begin
            wb_sum[j] = wb_sum[j] + FMT_W'(signed'(mem_q[wb_addr[j]]));
         end
         wb_word_d[j] = DATA_W'(npu_fmt(wb_sum[j], DATA_W));
      end
   end

   always_ff @(posedge clk_i) begin
      if (state_q == S_WB) begin
         for (int j = 0; j < N; j++) begin
            mem_q[wb_addr[j]] <= wb_word_d[j];
         end
      end else if (mem_we_i && !busy_q && host_in_range) begin
         mem_q[mem_addr_i] <= mem_wd_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q <= '0;
      end else if (mem_re_i && host_in_range) begin
         rd_q <= mem_q[mem_addr_i];
      end else begin
         rd_q <= '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         t_q        <= '0;
         r_q        <= '0;
         src1_q     <= '0;
         src2_q     <= '0;
         dst_q      <= '0;
         acc_mode_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  if (cmd_bad) begin
                     err_q <= 1'b1;
                  end else begin
                     src1_q     <= src1_addr_i;
                     src2_q     <= src2_addr_i;
                     dst_q      <= dst_addr_i;
                     acc_mode_q <= acc_mode_i;
                     t_q        <= '0;
                     busy_q     <= 1'b1;
                     state_q    <= S_FEED;
                  end
               end
            end
            S_FEED: begin
               if (t_q == TW'(3 * N - 2)) begin
                  r_q     <= '0;
                  state_q <= S_WB;
               end else begin
                  t_q <= t_q + 1'b1;
               end
            end
            S_WB: begin
               if (r_q == RW'(N - 1)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  r_q <= r_q + 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign cmd_err_o = err_q;
   assign mem_rd_o  = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_npu_gemm.sv
`default_nettype none
// ============================================================================
// tb_npu_gemm : randomized self-checking bench for npu_gemm against a plain matrix model.
// Revision: 1.0
// ============================================================================
module tb_npu_gemm;

   localparam int DATA_W = 32;
   localparam int N      = 3;
   localparam int DEPTH  = 64;
   localparam int AW     = 6;
   localparam int NN     = N * N;

   logic              clk      = 1'b0;
   logic              rst_n    = 1'b0;
   logic              start    = 1'b0;
   logic              acc_mode = 1'b0;
   logic              mem_we   = 1'b0;
   logic              mem_re   = 1'b0;
   logic [AW-1:0]     src1     = '0;
   logic [AW-1:0]     src2     = '0;
   logic [AW-1:0]     dst      = '0;
   logic [AW-1:0]     mem_addr = '0;
   logic [DATA_W-1:0] mem_wd   = '0;
   logic [DATA_W-1:0] mem_rd;
   logic              busy;
   logic              done;
   logic              cmd_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DATA_W-1:0] model_mem [DEPTH];

   always #5 clk = ~clk;

   npu_gemm #(
      .DATA_W (DATA_W),
      .N      (N),
      .DEPTH  (DEPTH)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .src1_addr_i (src1),
      .src2_addr_i (src2),
      .dst_addr_i  (dst),
      .acc_mode_i  (acc_mode),
      .busy_o      (busy),
      .done_o      (done),
      .cmd_err_o   (cmd_err),
      .mem_we_i    (mem_we),
      .mem_re_i    (mem_re),
      .mem_addr_i  (mem_addr),
      .mem_wd_i    (mem_wd),
      .mem_rd_o    (mem_rd)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic signed [127:0] sx(input logic [DATA_W-1:0] v);
      return {{(128-DATA_W){v[DATA_W-1]}}, v};
   endfunction

   function automatic logic [DATA_W-1:0] fmt(input logic signed [127:0] s);
      logic signed [127:0] hi;
      logic signed [127:0] lo;
      hi = 128'sd1 <<< (DATA_W - 1);
      lo = -hi;
      hi = hi - 128'sd1;
`ifdef NPU_SAT_EN
      if (s > hi) return DATA_W'(hi);
      if (s < lo) return DATA_W'(lo);
`endif
      return DATA_W'(s);
   endfunction

   // C computed from the pre-command image, so overlapping dst/src needs no special care.
   task automatic model_cmd(input int s1, input int s2, input int d, input bit accm);
      logic [DATA_W-1:0]   res [NN];
      logic signed [127:0] s;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            s = '0;
            for (int k = 0; k < N; k++)
               s = s + sx(model_mem[s1 + i*N + k]) * sx(model_mem[s2 + k*N + j]);
            if (accm) s = s + sx(model_mem[d + i*N + j]);
            res[i*N + j] = fmt(s);
         end
      end
      for (int x = 0; x < NN; x++) model_mem[d + x] = res[x];
   endtask

   task automatic host_write(input int a, input logic [DATA_W-1:0] v);
      mem_we = 1'b1; mem_addr = AW'(a); mem_wd = v;
      @(negedge clk);
      mem_we = 1'b0;
      model_mem[a] = v;
   endtask

   task automatic host_read(input int a, output logic [DATA_W-1:0] v);
      mem_re = 1'b1; mem_addr = AW'(a);
      @(negedge clk);
      v = mem_rd;
      mem_re = 1'b0;
   endtask

   task automatic check_mem(input string tag);
      logic [DATA_W-1:0] v;
      for (int a = 0; a < DEPTH; a++) begin
         host_read(a, v);
         chk($sformatf("%s_w%0d", tag, a), v, model_mem[a]);
      end
   endtask

   task automatic run_cmd(input int s1, input int s2, input int d, input bit accm, input bit intrude);
      int cnt;
      src1 = AW'(s1); src2 = AW'(s2); dst = AW'(d); acc_mode = accm; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 1;
      chk("busy_after_start", busy, 1);
      while (!done && cnt < 200) begin
         if (cnt == 4*N - 1) chk("busy_in_wb", busy, 1);
         mem_we   = intrude && (cnt == 2);
         mem_addr = '0;
         mem_wd   = 32'hDEAD;
         @(negedge clk);
         cnt++;
      end
      mem_we = 1'b0;
      chk("done_latency", cnt, 4*N);
      chk("busy_at_done", busy, 0);
      @(negedge clk);
      chk("done_pulse_width", done, 0);
      model_cmd(s1, s2, d, accm);
   endtask

   task automatic err_cmd(input int s1, input int s2, input int d);
      src1 = AW'(s1); src2 = AW'(s2); dst = AW'(d); acc_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("cmd_err_pulse", cmd_err, 1);
      chk("err_busy", busy, 0);
      @(negedge clk);
      chk("cmd_err_clear", cmd_err, 0);
      chk("err_busy_later", busy, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_W-1:0] v;
      int s1, s2, d, bad;

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cmd_err", cmd_err, 0);
      chk("rst_mem_rd", mem_rd, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int a = 0; a < DEPTH; a++) host_write(a, $urandom);

      // A = 1..9, B = identity
      for (int k = 0; k < NN; k++) host_write(k, DATA_W'(k + 1));
      for (int k = 0; k < NN; k++) host_write(9 + k, (k / N == k % N) ? 32'd1 : 32'd0);
      run_cmd(0, 9, 18, 1'b0, 1'b0);
      check_mem("ident");
      host_read(26, v);
      chk("ident_c22", v, 9);

      for (int k = 0; k < NN; k++) host_write(18 + k, 32'd100);
      run_cmd(0, 9, 18, 1'b1, 1'b0);
      check_mem("accum");
      host_read(18, v);
      chk("accum_c00", v, 101);
      @(negedge clk);
      chk("rd_zero_without_re", mem_rd, 0);

      err_cmd(0, 9, 60);
      err_cmd(DEPTH - NN + 1, 9, 18);
      check_mem("after_err");
      run_cmd(DEPTH - NN, 0, 46, 1'b0, 1'b0);
      check_mem("edge_base");

      run_cmd(0, 9, 30, 1'b0, 1'b1);
      host_read(0, v);
      chk("host_wr_dropped", v, 1);
      check_mem("intrude");

      // Abort mid-FEED at t = 4
      src1 = 0; src2 = 9; dst = 27; acc_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_mem("after_abort");
      run_cmd(0, 9, 27, 1'b1, 1'b0);
      check_mem("post_abort");

      // Overflowing magnitudes: both wrap and saturate paths get exercised
      for (int k = 0; k < NN; k++) host_write(k, 32'h7FFF_FFFF);
      for (int k = 0; k < NN; k++) host_write(9 + k, 32'h7FFF_FFFF);
      run_cmd(0, 9, 18, 1'b0, 1'b0);
      for (int k = 0; k < NN; k++) host_write(k, 32'h8000_0000);
      run_cmd(0, 9, 36, 1'b0, 1'b0);
      check_mem("extreme");

      for (int it = 0; it < 8; it++) begin
         for (int a = 0; a < DEPTH; a++) begin
            if (it % 2 == 0) host_write(a, $urandom);
            else             host_write(a, DATA_W'(int'($urandom_range(0, 30)) - 15));
         end
         s1 = int'($urandom_range(0, DEPTH - NN));
         s2 = int'($urandom_range(0, DEPTH - NN));
         d  = int'($urandom_range(0, DEPTH - NN));
         run_cmd(s1, s2, d, 1'($urandom_range(0, 1)), 1'b0);
         check_mem($sformatf("rand%0d", it));
      end

      for (int it = 0; it < 4; it++) begin
         s1  = int'($urandom_range(0, DEPTH - NN));
         s2  = int'($urandom_range(0, DEPTH - NN));
         d   = int'($urandom_range(0, DEPTH - NN));
         bad = int'($urandom_range(DEPTH - NN + 1, DEPTH - 1));
         case (it % 3)
            0:       err_cmd(bad, s2, d);
            1:       err_cmd(s1, bad, d);
            default: err_cmd(s1, s2, bad);
         endcase
      end
      check_mem("rand_err");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
